gauss_sa_ctrl: RTL and testbench
================================

# gauss_sa_ctrl

Sequencing controller for the Gaussian-elimination systolic array (`comb_SA`).
- Accepts a square binary matrix from a host one row per handshake and buffers it.
- Streams the rows into the array on consecutive cycles with a start pulse aligned to row 0, then waits for the array's finish flag.
- Returns the full-rank verdict through a result handshake.
- Sits between the host/DMA interface and the array instance. It is the only agent that drives the array's `start` and `data` inputs.

## Interface
Parameters:
- `DAT_W`, 4: matrix dimension. Row width equals row count.
- `TIMEOUT`, 64: maximum WAIT cycles before the watchdog fires (≥2).

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_b`  in  1  reset, asynchronous, active-low.
- `row_valid`  in  1  host row available.
- `row_ready`  out  1  controller accepts a row (state LOAD).
- `row_data`  in  DAT_W  matrix row. MSB is column 0.
- `abort`  in  1  synchronous abort; returns the controller to LOAD.
- `sa_start`  out  1  one-cycle start pulse to the array.
- `sa_data`  out  DAT_W  row presented to the array.
- `sa_finish`  in  1  array finish flag.
- `sa_full_rank`  in  1  array rank verdict. Valid in the cycle `sa_finish`=1.
- `res_valid`  out  1  result available (state DONE).
- `res_ready`  in  1  host consumes the result.
- `res_full_rank`  out  1  captured verdict.
- `res_timeout`  out  1  watchdog fired; verdict invalid.
- `busy`  out  1  high in FEED or WAIT.

## Operation
- Buffer: DAT_W×DAT_W register file, written at index `row_cnt`.
- `row_cnt` is a $clog2(DAT_W)-bit counter, minimum 1 bit. It is reused to index rows in FEED.
- States: LOAD (reset state), FEED, WAIT, DONE.
- LOAD:
  - `row_ready`=1.
  - On `row_valid&row_ready`, store `row_data` and increment `row_cnt`.
  - After the DAT_W-th accepted row, clear `row_cnt` and go to FEED.
  - Gaps in `row_valid` stall without loss.
- FEED:
  - Lasts exactly DAT_W cycles.
  - Each cycle drives the buffered row `row_cnt` onto `sa_data`.
  - `sa_start`=1 only in the cycle row 0 is driven.
  - After row DAT_W-1, go to WAIT.
- WAIT:
  - `sa_data`=0 and `sa_start`=0.
  - A watchdog counter increments every cycle.
  - On `sa_finish`=1, capture `sa_full_rank` into `res_full_rank`, clear `res_timeout`, and go to DONE.
  - If the counter reaches TIMEOUT-1 without `sa_finish`, set `res_timeout`=1 and `res_full_rank`=0, and go to DONE.
  - If `sa_finish` and the timeout coincide, `sa_finish` wins.
- DONE:
  - `res_valid`=1 with the results held stable.
  - On `res_ready`, go to LOAD, clear `row_cnt`, and hold `res_*` until the next capture.
  - No new rows are accepted while DONE.
- `sa_finish` outside WAIT is ignored.
- `abort`:
  - Takes effect at the next edge from any state: go to LOAD, clear counters, deassert `sa_start`, zero `sa_data`.
  - The buffer contents are not cleared but are overwritten by the next load.
  - `abort` wins over any simultaneous handshake. A row presented in that cycle is not stored.
  - After an abort from FEED/WAIT, the array is not re-started until a full new matrix is loaded. A late `sa_finish` is ignored.

## Timing
- All outputs are registered except `row_ready`, `res_valid` and `busy`, which decode directly from the state register.
- Reset values: state=LOAD, `row_ready`=1, `sa_start`=0, `sa_data`=0, `res_valid`=0, `res_full_rank`=0, `res_timeout`=0, `busy`=0, counters=0.
- Last row accepted at edge E: `sa_start`=1 and `sa_data`=row 0 in the cycle after E. Row k appears k cycles later.
- `sa_finish` sampled high at edge F: `res_valid`=1 in the cycle after F.
- Minimum matrix-to-matrix period: DAT_W (load) + DAT_W (feed) + array latency + 2 cycles.

## Configuration
- `GE_SA_TIMEOUT_EN`:
  - Defined: the WAIT watchdog is built as described.
  - Undefined: no watchdog counter, `res_timeout` is tied to 0, and WAIT exits only on `sa_finish` or `abort`.

## Test plan
- Identity matrix 4'b1000, 4'b0100, 4'b0010, 4'b0001, `res_ready`=1 → `sa_start` one cycle with `sa_data`=4'b1000, then 0100, 0010, 0001 on consecutive cycles; `res_full_rank`=1, `res_timeout`=0; `row_ready` back to 1 after the handshake.
- Rows 1100, 0110, 1010, 0001 (row 2 = row 0 ⊕ row 1) → `res_full_rank`=0 and `res_timeout`=0.
- Rows delivered with 2-cycle gaps on `row_valid`, and `res_ready` held low 5 cycles → FEED order is unchanged; `res_valid` and `res_full_rank` stay stable for 5 cycles; `row_ready`=0 throughout DONE.
- `sa_finish` stubbed to 0 with macro defined, TIMEOUT=64 → DONE entered 64 cycles after WAIT entry with `res_timeout`=1 and `res_full_rank`=0. Macro undefined → `busy` stays 1 indefinitely.
- `rst_b` low mid-FEED (after row 1) → all outputs take reset values immediately with no clock edge, and no further `sa_start` occurs. `abort` mid-WAIT followed by a late `sa_finish` → state LOAD and `res_valid` stays 0.

Source files
------------

// File: rtl/gauss_sa_ctrl.sv
// Sequencing controller for the comb_SA Gaussian-elimination array: buffers a
// DAT_W x DAT_W matrix, streams it in, returns the rank verdict. Optional WAIT
// watchdog is built when GE_SA_TIMEOUT_EN is defined.
module gauss_sa_ctrl #(
  parameter int DAT_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             row_valid,
  output logic             row_ready,
  input  logic [DAT_W-1:0] row_data,
  input  logic             abort,
  output logic             sa_start,
  output logic [DAT_W-1:0] sa_data,
  input  logic             sa_finish,
  input  logic             sa_full_rank,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_full_rank,
  output logic             res_timeout,
  output logic             busy
);

  localparam int CNT_W = (DAT_W > 1) ? $clog2(DAT_W) : 1;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(DAT_W - 1);

  if (TIMEOUT < 2) begin : g_timeout_check
    $error("gauss_sa_ctrl: TIMEOUT must be at least 2");
  end

  typedef enum logic [1:0] {ST_LOAD, ST_FEED, ST_WAIT, ST_DONE} state_t;

  state_t           state_q, state_d;
  logic [DAT_W-1:0] buf_q [DAT_W];
  logic [CNT_W-1:0] row_cnt;
  logic [CNT_W-1:0] row_nxt;
  logic             accept, last_row, wd_hit, finish_hit, timeout_hit;

  assign row_ready = (state_q == ST_LOAD);
  assign res_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_FEED) || (state_q == ST_WAIT);

  assign row_nxt     = row_cnt + CNT_W'(1);
  assign last_row    = (row_cnt == LAST_ROW);
  assign accept      = row_ready && row_valid && !abort;
  assign finish_hit  = (state_q == ST_WAIT) && sa_finish && !abort;
  // finish has priority over a coincident watchdog expiry
  assign timeout_hit = (state_q == ST_WAIT) && !sa_finish && wd_hit && !abort;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= ST_LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_LOAD;
    end else begin
      unique case (state_q)
        ST_LOAD: if (accept && last_row) state_d = ST_FEED;
        ST_FEED: if (last_row)           state_d = ST_WAIT;
        ST_WAIT: if (sa_finish || wd_hit) state_d = ST_DONE;
        ST_DONE: if (res_ready)          state_d = ST_LOAD;
        default:                         state_d = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) buf_q[row_cnt] <= row_data;
  end

  // sa_data is registered one row ahead: the edge that accepts the last row
  // already loads row 0, and each FEED edge loads the following row.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      row_cnt  <= '0;
      sa_start <= 1'b0;
      sa_data  <= '0;
    end else if (abort) begin
      row_cnt  <= '0;
      sa_start <= 1'b0;
      sa_data  <= '0;
    end else begin
      sa_start <= 1'b0;
      sa_data  <= '0;
      case (state_q)
        ST_LOAD: begin
          if (accept) begin
            if (last_row) begin
              row_cnt  <= '0;
              sa_start <= 1'b1;
              sa_data  <= (DAT_W == 1) ? row_data : buf_q[0];
            end else begin
              row_cnt <= row_nxt;
            end
          end
        end
        ST_FEED: begin
          if (last_row) begin
            row_cnt <= '0;
          end else begin
            row_cnt <= row_nxt;
            sa_data <= buf_q[row_nxt];
          end
        end
        ST_DONE: if (res_ready) row_cnt <= '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)           res_full_rank <= 1'b0;
    else if (finish_hit)  res_full_rank <= sa_full_rank;
    else if (timeout_hit) res_full_rank <= 1'b0;
  end

`ifdef GE_SA_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT);

  logic [WD_W-1:0] wd_cnt;

  assign wd_hit = (wd_cnt == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wd_cnt <= '0;
    end else if (state_q == ST_WAIT && state_d == ST_WAIT) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end else begin
      wd_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)           res_timeout <= 1'b0;
    else if (finish_hit)  res_timeout <= 1'b0;
    else if (timeout_hit) res_timeout <= 1'b1;
  end
`else
  assign wd_hit      = 1'b0;
  assign res_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_gauss_sa_ctrl.sv
// Directed self-checking bench for gauss_sa_ctrl with a scoreboard of expected
// feed rows and rank verdicts, plus a behavioural stand-in for the array.
module tb_gauss_sa_ctrl;

  localparam int DW = 4;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          row_valid = 1'b0;
  logic [DW-1:0] row_data = '0;
  logic          abort = 1'b0;
  logic          sa_finish = 1'b0;
  logic          sa_full_rank = 1'b0;
  logic          res_ready = 1'b0;
  logic          row_ready, sa_start, res_valid, res_full_rank, res_timeout, busy;
  logic [DW-1:0] sa_data;

  int n_checks = 0;
  int n_fail = 0;

  logic [DW-1:0] exp_rows [$];
  logic          exp_rank [$];

  always #5 clk = ~clk;

  gauss_sa_ctrl #(.DAT_W(DW), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .row_valid    (row_valid),
    .row_ready    (row_ready),
    .row_data     (row_data),
    .abort        (abort),
    .sa_start     (sa_start),
    .sa_data      (sa_data),
    .sa_finish    (sa_finish),
    .sa_full_rank (sa_full_rank),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_full_rank(res_full_rank),
    .res_timeout  (res_timeout),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // GF(2) rank test; row i of the matrix is m[i*DW +: DW]
  function automatic logic full_rank(input logic [DW*DW-1:0] m);
    logic [DW-1:0] r [DW];
    logic [DW-1:0] t;
    int rank = 0;
    for (int i = 0; i < DW; i++) r[i] = m[i*DW +: DW];
    for (int c = DW - 1; c >= 0; c--) begin
      int p = -1;
      for (int i = rank; i < DW; i++) if (p < 0 && r[i][c]) p = i;
      if (p >= 0) begin
        t = r[rank]; r[rank] = r[p]; r[p] = t;
        for (int i = 0; i < DW; i++) if (i != rank && r[i][c]) r[i] = r[i] ^ r[rank];
        rank++;
      end
    end
    return (rank == DW);
  endfunction

  function automatic logic [DW-1:0] pop_row();
    if (exp_rows.size() == 0) return 'x;
    return exp_rows.pop_front();
  endfunction

  function automatic logic pop_rank();
    if (exp_rank.size() == 0) return 1'bx;
    return exp_rank.pop_front();
  endfunction

  task automatic load_matrix(input logic [DW*DW-1:0] m, input int gap);
    for (int i = 0; i < DW; i++) begin
      row_valid = 1'b0;
      repeat (gap) tick();
      row_valid = 1'b1;
      row_data  = m[i*DW +: DW];
      check("row_ready_load", row_ready, 1);
      exp_rows.push_back(m[i*DW +: DW]);
      tick();
    end
    row_valid = 1'b0;
    row_data  = '0;
    exp_rank.push_back(full_rank(m));
  endtask

  // Observes the feed, and returns the verdict an ideal array would give
  task automatic feed_check(output logic verdict);
    logic [DW*DW-1:0] seen = '0;
    for (int i = 0; i < DW; i++) begin
      check("feed_start", sa_start, (i == 0) ? 1 : 0);
      check("feed_data", sa_data, pop_row());
      check("feed_busy", busy, 1);
      seen[i*DW +: DW] = sa_data;
      tick();
    end
    check("wait_data", sa_data, 0);
    check("wait_start", sa_start, 0);
    verdict = full_rank(seen);
  endtask

  task automatic finish_result(input int latency, input logic verdict, output logic exp_v);
    repeat (latency) tick();
    sa_finish    = 1'b1;
    sa_full_rank = verdict;
    tick();
    sa_finish    = 1'b0;
    sa_full_rank = 1'b0;
    exp_v = pop_rank();
    check("res_valid", res_valid, 1);
    check("res_full_rank", res_full_rank, exp_v);
    check("res_timeout", res_timeout, 0);
    check("done_busy", busy, 0);
    check("done_row_ready", row_ready, 0);
  endtask

  task automatic release_result(input int hold, input logic exp_v, input logic poke_row);
    res_ready = 1'b0;
    if (poke_row) begin
      row_valid = 1'b1;
      row_data  = '1;
    end
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", res_valid, 1);
      check("hold_full_rank", res_full_rank, exp_v);
      check("hold_row_ready", row_ready, 0);
      tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    row_valid = 1'b0;
    row_data  = '0;
    check("post_row_ready", row_ready, 1);
    check("post_res_valid", res_valid, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    logic v, e;
    int   n;

    #2;
    check("rst_row_ready", row_ready, 1);
    check("rst_sa_start", sa_start, 0);
    check("rst_sa_data", sa_data, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_full_rank", res_full_rank, 0);
    check("rst_timeout", res_timeout, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    tick();

    // identity matrix
    load_matrix(16'h1248, 0);
    feed_check(v);
    finish_result(3, v, e);
    release_result(0, e, 1'b0);

    // rank-deficient: row 2 = row 0 ^ row 1
    load_matrix(16'h1A6C, 0);
    feed_check(v);
    finish_result(5, v, e);
    release_result(0, e, 1'b0);

    // gapped rows, delayed result consumption, row offered during DONE
    load_matrix(16'h835B, 2);
    feed_check(v);
    finish_result(1, v, e);
    release_result(5, e, 1'b1);

    // a row offered during DONE must not have been captured
    load_matrix(16'h1248, 0);
    feed_check(v);
    finish_result(2, v, e);
    release_result(1, e, 1'b0);

    // array never finishes
    load_matrix(16'h1248, 0);
    feed_check(v);
`ifdef GE_SA_TIMEOUT_EN
    n = 0;
    while (res_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("timeout_cycles", n, TO);
    check("timeout_flag", res_timeout, 1);
    check("timeout_full_rank", res_full_rank, 0);
    void'(pop_rank());
    release_result(2, 1'b0, 1'b0);
`else
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy !== 1'b1 || res_valid !== 1'b0) n++;
      tick();
    end
    check("no_watchdog_busy", n, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_hang_ready", row_ready, 1);
    check("abort_hang_busy", busy, 0);
    void'(pop_rank());
`endif

    // asynchronous reset while row 1 is being fed
    load_matrix(16'h8421, 0);
    check("pre_rst_row0", sa_data, pop_row());
    tick();
    check("pre_rst_row1", sa_data, pop_row());
    #2;
    rst_b = 1'b0;
    #1;
    check("arst_row_ready", row_ready, 1);
    check("arst_sa_start", sa_start, 0);
    check("arst_sa_data", sa_data, 0);
    check("arst_res_valid", res_valid, 0);
    check("arst_full_rank", res_full_rank, 0);
    check("arst_timeout", res_timeout, 0);
    check("arst_busy", busy, 0);
    exp_rows.delete();
    exp_rank.delete();
    tick();
    tick();
    rst_b = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (sa_start !== 1'b0) n++;
      tick();
    end
    check("no_start_after_reset", n, 0);

    // abort in WAIT, then a late finish
    load_matrix(16'h1A6C, 0);
    feed_check(v);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_row_ready", row_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_res_valid", res_valid, 0);
    check("abort_sa_data", sa_data, 0);
    void'(pop_rank());
    sa_finish    = 1'b1;
    sa_full_rank = 1'b1;
    tick();
    sa_finish    = 1'b0;
    sa_full_rank = 1'b0;
    check("late_finish_valid", res_valid, 0);
    check("late_finish_ready", row_ready, 1);

    // abort beats a simultaneous row handshake
    row_valid = 1'b1;
    row_data  = '1;
    abort     = 1'b1;
    tick();
    abort     = 1'b0;
    row_valid = 1'b0;
    load_matrix(16'h1248, 0);
    feed_check(v);
    finish_result(4, v, e);
    release_result(0, e, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
